// File: rtl/mips_run_monitor.sv
// Run controller and circular PC/instruction trace monitor for the 16-bit MIPS core.
// Define MON_CHECKSUM_EN to add a rotate-xor signature of alu_result over each run.
module mips_run_monitor #(
  parameter int          DATA_W      = 16,
  parameter int          TRACE_DEPTH = 16,
  parameter int          MAX_CYCLES  = 1000,
  parameter int          STALL_LIMIT = 4,
  parameter logic [3:0]  HALT_OP     = 4'hF,
  localparam int         CNT_W       = $clog2(MAX_CYCLES + 1),
  localparam int         IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] alu_result,
  output logic              core_en,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [IDX_W:0]    trace_count,
  input  logic              trace_rd_en,
  input  logic [IDX_W-1:0]  trace_rd_idx,
  output logic              trace_rd_valid,
  output logic [DATA_W-1:0] trace_rd_pc,
  output logic [DATA_W-1:0] trace_rd_instr,
`ifdef MON_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [1:0]        dbg_state
);

  localparam int TC_W  = IDX_W + 1;
  localparam int STL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem_pc    [TRACE_DEPTH];
  logic [DATA_W-1:0] r_mem_instr [TRACE_DEPTH];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [STL_W-1:0]  r_stall_cnt;
  logic [DATA_W-1:0] r_prev_pc;
  logic              r_first;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [TC_W-1:0]   r_trace_count;
  logic [1:0]        r_halt_reason;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_pc;
  logic [DATA_W-1:0] r_rd_instr;

  logic              w_run;
  logic              w_start_ok;
  logic              w_full;
  logic [STL_W-1:0]  w_stall_next;
  logic              w_hit_halt;
  logic              w_hit_stall;
  logic              w_hit_limit;
  logic [IDX_W-1:0]  w_rd_slot;
  logic              w_rd_in_range;

  assign w_run       = (r_state == ST_RUN);
  assign w_start_ok  = start && (r_state != ST_RUN);
  assign w_full      = (r_trace_count == TC_W'(TRACE_DEPTH));

  // The first RUN cycle has no meaningful previous PC, so it never counts as a repeat.
  assign w_stall_next = ((pc == r_prev_pc) && !r_first) ? (r_stall_cnt + STL_W'(1)) : '0;
  assign w_hit_halt   = (instr[DATA_W-1 -: 4] == HALT_OP);
  assign w_hit_stall  = (w_stall_next == STL_W'(STALL_LIMIT));
  assign w_hit_limit  = ((r_cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES));

  // Once the ring has wrapped, index 0 (oldest) lives at the write pointer.
  assign w_rd_slot     = w_full ? (r_wr_ptr + trace_rd_idx) : trace_rd_idx;
  assign w_rd_in_range = ({1'b0, trace_rd_idx} < r_trace_count);

  // Trace storage: no reset; only slots below trace_count are ever exposed.
  always_ff @(posedge clk) begin
    if (w_run) begin
      r_mem_pc[r_wr_ptr]    <= pc;
      r_mem_instr[r_wr_ptr] <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_stall_cnt   <= '0;
      r_prev_pc     <= '0;
      r_first       <= 1'b0;
      r_cycle_count <= '0;
      r_trace_count <= '0;
      r_halt_reason <= 2'b00;
      r_rd_valid    <= 1'b0;
      r_rd_pc       <= '0;
      r_rd_instr    <= '0;
    end else begin
      // Trace read: trace_rd_en is a single-cycle request that is always accepted;
      // trace_rd_valid is high exactly the next cycle, with the slot's pre-write data.
      r_rd_valid <= trace_rd_en;
      if (trace_rd_en) begin
        r_rd_pc    <= w_rd_in_range ? r_mem_pc[w_rd_slot]    : '0;
        r_rd_instr <= w_rd_in_range ? r_mem_instr[w_rd_slot] : '0;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_cycle_count <= '0;
            r_trace_count <= '0;
            r_wr_ptr      <= '0;
            r_stall_cnt   <= '0;
            r_halt_reason <= 2'b00;
            r_first       <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_wr_ptr      <= r_wr_ptr + IDX_W'(1);
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (!w_full) begin
            r_trace_count <= r_trace_count + TC_W'(1);
          end
          r_stall_cnt <= w_stall_next;
          r_prev_pc   <= pc;
          r_first     <= 1'b0;
          if (w_hit_halt) begin
            r_halt_reason <= 2'b11;
            r_state       <= ST_DONE;
          end else if (w_hit_stall) begin
            r_halt_reason <= 2'b01;
            r_state       <= ST_DONE;
          end else if (w_hit_limit) begin
            r_halt_reason <= 2'b10;
            r_state       <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MON_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_run) begin
      r_checksum <= {r_checksum[DATA_W-2:0], r_checksum[DATA_W-1]} ^ alu_result;
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_alu;
  assign w_unused_alu = ^{alu_result, w_start_ok};
`endif

  assign core_en        = w_run;
  assign running        = w_run;
  assign done           = (r_state == ST_DONE);
  assign halt_reason    = r_halt_reason;
  assign cycle_count    = r_cycle_count;
  assign trace_count    = r_trace_count;
  assign trace_rd_valid = r_rd_valid;
  assign trace_rd_pc    = r_rd_pc;
  assign trace_rd_instr = r_rd_instr;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor: two instances (MAX_CYCLES 20 and 3) driven by directed runs.
module tb_mips_run_monitor;

  logic        clk, rst;
  logic        start_a, start_b, rd_en_a, rd_en_b;
  logic [15:0] pc, instr, alu;
  logic [3:0]  rd_idx;

  logic        core_en_a, running_a, done_a, rvalid_a;
  logic [1:0]  reason_a, dbg_a;
  logic [4:0]  cyc_a, tc_a;
  logic [15:0] rpc_a, rinstr_a;
  logic        core_en_b, running_b, done_b, rvalid_b;
  logic [1:0]  reason_b, dbg_b;
  logic [1:0]  cyc_b;
  logic [4:0]  tc_b;
  logic [15:0] rpc_b, rinstr_b;
  logic [15:0] csum_a, csum_b;

  mips_run_monitor #(.MAX_CYCLES(20), .STALL_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pc(pc), .instr(instr), .alu_result(alu),
    .core_en(core_en_a), .running(running_a), .done(done_a), .halt_reason(reason_a),
    .cycle_count(cyc_a), .trace_count(tc_a), .trace_rd_en(rd_en_a), .trace_rd_idx(rd_idx),
    .trace_rd_valid(rvalid_a), .trace_rd_pc(rpc_a), .trace_rd_instr(rinstr_a),
`ifdef MON_CHECKSUM_EN
    .checksum(csum_a),
`endif
    .dbg_state(dbg_a)
  );

  mips_run_monitor #(.MAX_CYCLES(3), .STALL_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pc(pc), .instr(instr), .alu_result(alu),
    .core_en(core_en_b), .running(running_b), .done(done_b), .halt_reason(reason_b),
    .cycle_count(cyc_b), .trace_count(tc_b), .trace_rd_en(rd_en_b), .trace_rd_idx(rd_idx),
    .trace_rd_valid(rvalid_b), .trace_rd_pc(rpc_b), .trace_rd_instr(rinstr_b),
`ifdef MON_CHECKSUM_EN
    .checksum(csum_b),
`endif
    .dbg_state(dbg_b)
  );

`ifndef MON_CHECKSUM_EN
  assign csum_a = '0;
  assign csum_b = '0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];       // {pc, instr} per trace read
  logic [39:0] run_exp_a_q[$]; // {6'b0, reason, cyc[7:0], tc[7:0], checksum}
  logic [39:0] run_exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_run(input string tag, input logic [39:0] e, input logic [1:0] reason,
                           input logic [7:0] cyc, input logic [7:0] tc, input logic [15:0] cs,
                           input logic cen);
    check({tag, "_reason"}, 32'(reason), 32'(e[33:32]));
    check({tag, "_cycles"}, 32'(cyc), 32'(e[31:24]));
    check({tag, "_trace_count"}, 32'(tc), 32'(e[23:16]));
    check({tag, "_core_en"}, 32'(cen), 32'd0);
`ifdef MON_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(cs), 32'(e[15:0]));
`else
    if (cs !== 16'h0) check({tag, "_checksum_tie"}, 32'(cs), 32'd0);
`endif
  endtask

  // monitor: pops whenever a DUT presents a completed run or read data
  logic done_a_q, done_b_q;
  always @(negedge clk) begin
    if (rst) begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      done_a_q <= done_a;
      done_b_q <= done_b;
      if (done_a && !done_a_q) begin
        if (run_exp_a_q.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
        else check_run("a", run_exp_a_q.pop_front(), reason_a, 8'(cyc_a), 8'(tc_a), csum_a, core_en_a);
      end
      if (done_b && !done_b_q) begin
        if (run_exp_b_q.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
        else check_run("b", run_exp_b_q.pop_front(), reason_b, 8'(cyc_b), 8'(tc_b), csum_b, core_en_b);
      end
      if (rvalid_a) begin
        if (exp_q.size() == 0) check("rd_unexpected_valid", 32'd1, 32'd0);
        else check("rd_data", {rpc_a, rinstr_a}, exp_q.pop_front());
      end
    end
  end

  // driver
  logic [15:0] v_pc[32], v_instr[32], v_alu[32];

  task automatic drive(input bit which, input int n, input logic [1:0] reason, input int tc);
    logic [15:0] cs;
    cs = '0;
    for (int i = 0; i < n; i++) cs = {cs[14:0], cs[15]} ^ v_alu[i];
    if (!which) run_exp_a_q.push_back({6'b0, reason, 8'(n), 8'(tc), cs});
    else        run_exp_b_q.push_back({6'b0, reason, 8'(n), 8'(tc), cs});
    if (!which) start_a = 1'b1;
    else        start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (!which) begin
      check("start_running_a", 32'(running_a), 32'd1);
      check("start_cyc_clear_a", 32'(cyc_a), 32'd0);
    end else begin
      check("start_running_b", 32'(running_b), 32'd1);
      check("start_cyc_clear_b", 32'(cyc_b), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      pc = v_pc[i]; instr = v_instr[i]; alu = v_alu[i];
      @(posedge clk); #1;
    end
    pc = '0; instr = '0; alu = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [15:0] epc, input logic [15:0] einstr);
    exp_q.push_back({epc, einstr});
    rd_idx = idx;
    rd_en_a = 1'b1;
    @(posedge clk); #1;
    rd_en_a = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; rd_en_a = 0; rd_en_b = 0;
    pc = '0; instr = '0; alu = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_a), 32'd0);
    check("rst_core_en", 32'(core_en_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_cyc", 32'(cyc_a), 32'd0);
    check("rst_rd_valid", 32'(rvalid_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a run
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 16'(2 * i); instr = 16'h1234;
      @(posedge clk); #1;
    end
    check("midrun_running", 32'(running_a), 32'd1);
    check("midrun_cyc", 32'(cyc_a), 32'd5);
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(dbg_a), 32'd0);
    check("midrst_core_en", 32'(core_en_a), 32'd0);
    check("midrst_trace_count", 32'(tc_a), 32'd0);
    check("midrst_reason", 32'(reason_a), 32'd0);
    check("midrst_cyc", 32'(cyc_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // halt opcode after 6 ordinary instructions
    for (int i = 0; i < 7; i++) begin
      v_pc[i] = 16'(2 * i); v_instr[i] = (i == 6) ? 16'hF000 : 16'h1234; v_alu[i] = 16'h0000;
    end
    v_alu[0] = 16'h0001; v_alu[1] = 16'h0002; v_alu[2] = 16'h8000;
    drive(1'b0, 7, 2'b11, 7);
    rd(4'd2, 16'd4, 16'h1234);
    rd(4'd6, 16'd12, 16'hF000);
    rd(4'd7, 16'h0000, 16'h0000);

    // PC stall: 0, 2, 4, 4, 4, 4, 4
    for (int i = 0; i < 7; i++) begin
      v_pc[i] = (i < 2) ? 16'(2 * i) : 16'd4; v_instr[i] = 16'h1234; v_alu[i] = 16'(3 * i + 1);
    end
    drive(1'b0, 7, 2'b01, 7);

    // cycle limit with wrapped trace
    for (int i = 0; i < 20; i++) begin
      v_pc[i] = 16'(2 * i); v_instr[i] = 16'h1000 | 16'(i); v_alu[i] = 16'(i * 257);
    end
    drive(1'b0, 20, 2'b10, 16);
    rd(4'd0, 16'd8, 16'h1004);
    rd(4'd15, 16'd38, 16'h1013);
    rd(4'd5, 16'd18, 16'h1009);

    // halt opcode and limit on the same cycle
    v_pc[0] = 16'd0; v_pc[1] = 16'd2; v_pc[2] = 16'd4;
    v_instr[0] = 16'h1234; v_instr[1] = 16'h1234; v_instr[2] = 16'hF000;
    v_alu[0] = 16'h00A5; v_alu[1] = 16'h5A00; v_alu[2] = 16'hFFFF;
    drive(1'b1, 3, 2'b11, 3);
    // restart from DONE; first cycle repeats last PC but must not count as a stall; stall wins over limit
    for (int i = 0; i < 3; i++) begin
      v_pc[i] = 16'd4; v_instr[i] = 16'h1234; v_alu[i] = 16'h8001;
    end
    drive(1'b1, 3, 2'b01, 3);
    // limit alone
    for (int i = 0; i < 3; i++) begin
      v_pc[i] = 16'(10 + 2 * i); v_instr[i] = 16'h2345; v_alu[i] = 16'(i + 7);
    end
    drive(1'b1, 3, 2'b10, 3);

    repeat (4) @(posedge clk);
    #1;
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    check("pending_runs_a", 32'(run_exp_a_q.size()), 32'd0);
    check("pending_runs_b", 32'(run_exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
